// File: rtl/dma_engine.sv
// Word-granular DMA sequencer: copies len bytes one word at a time between the
// host bus and device-local memory over two OBI-style master ports.
module dma_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    input  logic                  dir_i,
    input  logic                  start_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  host_req_o,
    input  logic                  host_gnt_i,
    output logic                  host_we_o,
    output logic [ADDR_WIDTH-1:0] host_addr_o,
    output logic [31:0]           host_wdata_o,
    input  logic                  host_rvalid_i,
    input  logic [31:0]           host_rdata_i,
    output logic                  dev_req_o,
    input  logic                  dev_gnt_i,
    output logic                  dev_we_o,
    output logic [ADDR_WIDTH-1:0] dev_addr_o,
    output logic [31:0]           dev_wdata_o,
    input  logic                  dev_rvalid_i,
    input  logic [31:0]           dev_rdata_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_e;

    localparam int WW = LEN_WIDTH - 2;
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);
    localparam logic [WW-1:0]         ONE_WORD   = WW'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [WW-1:0]         words_q, words_d;
    logic                  dir_q, dir_d;
    logic [31:0]           buf_q, buf_d;
    logic                  done_q, done_d;

    // dir_q=0: host is the source side, device the destination side
    logic        src_gnt_s, src_rvalid_s, dst_gnt_s, dst_rvalid_s;
    logic [31:0] src_rdata_s;
    assign src_gnt_s    = dir_q ? dev_gnt_i    : host_gnt_i;
    assign src_rvalid_s = dir_q ? dev_rvalid_i : host_rvalid_i;
    assign src_rdata_s  = dir_q ? dev_rdata_i  : host_rdata_i;
    assign dst_gnt_s    = dir_q ? host_gnt_i   : dev_gnt_i;
    assign dst_rvalid_s = dir_q ? host_rvalid_i : dev_rvalid_i;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            words_q <= '0;
            dir_q   <= 1'b0;
            buf_q   <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            words_q <= words_d;
            dir_q   <= dir_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        words_d = words_q;
        dir_d   = dir_q;
        buf_d   = buf_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = {src_i[ADDR_WIDTH-1:2], 2'b00};
                    dst_d   = {dst_i[ADDR_WIDTH-1:2], 2'b00};
                    words_d = len_i[LEN_WIDTH-1:2];
                    dir_d   = dir_i;
                    // A zero-length request completes immediately without touching either bus
                    if (len_i[LEN_WIDTH-1:2] == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        done_d  = 1'b0;
                        state_d = RD_REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (src_gnt_s) state_d = RD_WAIT;
                else           state_d = RD_REQ;
            end
            RD_WAIT: begin
                if (src_rvalid_s) begin
                    buf_d   = src_rdata_s;
                    state_d = WR_REQ;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (dst_gnt_s) state_d = WR_WAIT;
                else           state_d = WR_REQ;
            end
            WR_WAIT: begin
                if (dst_rvalid_s) begin
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    words_d = words_q - ONE_WORD;
                    if (words_q == ONE_WORD) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else begin
                    state_d = WR_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port drive decoded from registered state, so reset drops requests at once
    always_comb begin
        host_req_o   = 1'b0;
        host_we_o    = 1'b0;
        host_addr_o  = '0;
        host_wdata_o = 32'd0;
        dev_req_o    = 1'b0;
        dev_we_o     = 1'b0;
        dev_addr_o   = '0;
        dev_wdata_o  = 32'd0;
        case (state_q)
            RD_REQ: begin
                if (dir_q) begin
                    dev_req_o  = 1'b1;
                    dev_addr_o = src_q;
                end else begin
                    host_req_o  = 1'b1;
                    host_addr_o = src_q;
                end
            end
            WR_REQ: begin
                if (dir_q) begin
                    host_req_o   = 1'b1;
                    host_we_o    = 1'b1;
                    host_addr_o  = dst_q;
                    host_wdata_o = buf_q;
                end else begin
                    dev_req_o   = 1'b1;
                    dev_we_o    = 1'b1;
                    dev_addr_o  = dst_q;
                    dev_wdata_o = buf_q;
                end
            end
            default: begin
                host_req_o = 1'b0;
                dev_req_o  = 1'b0;
            end
        endcase
    end

    assign done_o = done_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboarded bench for dma_engine: memory models with programmable grant stall,
// expected writes queued by the stimulus and popped by an independent monitor.
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] len, src, dst;
    logic        dir, start;
    logic        done, busy;
    logic        host_req, host_gnt, host_we, host_rvalid;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic        dev_req, dev_gnt, dev_we, dev_rvalid;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;

    always #5 clk = ~clk;

    dma_engine #(.ADDR_WIDTH(32), .LEN_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .len_i(len), .src_i(src), .dst_i(dst),
        .dir_i(dir), .start_i(start), .done_o(done), .busy_o(busy),
        .host_req_o(host_req), .host_gnt_i(host_gnt), .host_we_o(host_we),
        .host_addr_o(host_addr), .host_wdata_o(host_wdata),
        .host_rvalid_i(host_rvalid), .host_rdata_i(host_rdata),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_we_o(dev_we),
        .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        host;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Read-only memory models; grant after a programmable number of stall cycles
    logic [31:0] host_mem [logic [31:0]];
    logic [31:0] dev_mem  [logic [31:0]];
    int host_stall = 0, dev_stall = 0;
    int host_cnt = 0, dev_cnt = 0;

    assign host_gnt = host_req && (host_cnt == host_stall);
    assign dev_gnt  = dev_req  && (dev_cnt  == dev_stall);

    always @(posedge clk) begin
        host_cnt    <= (!host_req || host_gnt) ? 0 : host_cnt + 1;
        host_rvalid <= host_req && host_gnt;
        host_rdata  <= (host_req && host_gnt && !host_we && host_mem.exists(host_addr)) ? host_mem[host_addr] : 32'h0;
        dev_cnt     <= (!dev_req || dev_gnt) ? 0 : dev_cnt + 1;
        dev_rvalid  <= dev_req && dev_gnt;
        dev_rdata   <= (dev_req && dev_gnt && !dev_we && dev_mem.exists(dev_addr)) ? dev_mem[dev_addr] : 32'h0;
    end

    task automatic check_wr(input logic is_host, input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got port=%0d addr=0x%08h data=0x%08h expected none", is_host, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("wr_port", {31'd0, is_host}, {31'd0, e.host});
            chk("wr_addr", a, e.addr);
            chk("wr_data", d, e.data);
        end
    endtask

    logic        host_hold_q = 1'b0, dev_hold_q = 1'b0;
    logic        host_we_s_q, dev_we_s_q;
    logic [31:0] host_addr_s_q, host_wdata_s_q, dev_addr_s_q, dev_wdata_s_q;

    // Monitor: pops expected writes on granted write requests, checks stall stability
    always @(negedge clk) begin
        if (rst_ni) begin
            if (host_req && host_gnt && host_we) check_wr(1'b1, host_addr, host_wdata);
            if (dev_req && dev_gnt && dev_we)    check_wr(1'b0, dev_addr, dev_wdata);
            if (host_hold_q) begin
                chk("host_stall_req", {31'd0, host_req}, 32'd1);
                chk("host_stall_addr", host_addr, host_addr_s_q);
                chk("host_stall_we", {31'd0, host_we}, {31'd0, host_we_s_q});
                chk("host_stall_wdata", host_wdata, host_wdata_s_q);
            end
            if (dev_hold_q) begin
                chk("dev_stall_req", {31'd0, dev_req}, 32'd1);
                chk("dev_stall_addr", dev_addr, dev_addr_s_q);
                chk("dev_stall_we", {31'd0, dev_we}, {31'd0, dev_we_s_q});
                chk("dev_stall_wdata", dev_wdata, dev_wdata_s_q);
            end
            chk("busy_done_excl", {31'd0, busy && done}, 32'd0);
            host_hold_q    <= host_req && !host_gnt;
            host_addr_s_q  <= host_addr;
            host_we_s_q    <= host_we;
            host_wdata_s_q <= host_wdata;
            dev_hold_q     <= dev_req && !dev_gnt;
            dev_addr_s_q   <= dev_addr;
            dev_we_s_q     <= dev_we;
            dev_wdata_s_q  <= dev_wdata;
        end else begin
            host_hold_q <= 1'b0;
            dev_hold_q  <= 1'b0;
        end
    end

    // Drives a one-cycle start; returns at the negedge of cycle 1 (start cycle = 0)
    task automatic pulse_start(input logic d, input logic [31:0] s, input logic [31:0] t, input logic [31:0] l);
        @(posedge clk);
        #1;
        dir = d; src = s; dst = t; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 300) begin
            step();
            cyc++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", cyc);
        end
    endtask

    int c;

    initial begin
        rst_ni = 1'b0; start = 1'b0; dir = 1'b0;
        len = 32'd0; src = 32'd0; dst = 32'd0;
        host_mem[32'h1000] = 32'h1234_5678;
        for (int i = 0; i < 4; i++) dev_mem[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
        host_mem[32'h2000] = 32'hDEAD_BEEF;
        host_mem[32'h2004] = 32'hCAFE_F00D;
        host_mem[32'h2100] = 32'h1111_1111;
        host_mem[32'h2104] = 32'h2222_2222;
        for (int i = 0; i < 4; i++) host_mem[32'h2200 + 32'(4 * i)] = 32'h5500_0000 + 32'(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_host_req", {31'd0, host_req}, 32'd0);
        chk("rst_dev_req", {31'd0, dev_req}, 32'd0);
        chk("rst_host_addr", host_addr, 32'd0);
        chk("rst_dev_wdata", dev_wdata, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // T1: single word host->device, zero wait, cycle-accurate
        exp_q.push_back('{1'b0, 32'h0, 32'h1234_5678});
        pulse_start(1'b0, 32'h1000, 32'h0, 32'd4);
        chk("t1_c1_host_req", {31'd0, host_req}, 32'd1);
        chk("t1_c1_host_addr", host_addr, 32'h1000);
        chk("t1_c1_host_we", {31'd0, host_we}, 32'd0);
        chk("t1_c1_dev_req", {31'd0, dev_req}, 32'd0);
        chk("t1_c1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("t1_c2_host_req", {31'd0, host_req}, 32'd0);
        step();
        chk("t1_c3_dev_req", {31'd0, dev_req}, 32'd1);
        chk("t1_c3_dev_we", {31'd0, dev_we}, 32'd1);
        chk("t1_c3_dev_addr", dev_addr, 32'h0);
        chk("t1_c3_host_req", {31'd0, host_req}, 32'd0);
        step();
        chk("t1_c4_done", {31'd0, done}, 32'd0);
        step();
        chk("t1_c5_done", {31'd0, done}, 32'd1);
        chk("t1_c5_busy", {31'd0, busy}, 32'd0);

        // T2: four words device->host
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, 32'h800 + 32'(4 * i), 32'hA0 + 32'(i)});
        pulse_start(1'b1, 32'h40, 32'h800, 32'd16);
        chk("t2_done_cleared", {31'd0, done}, 32'd0);
        wait_done(1, c);
        chk("t2_cycles", 32'(c), 32'd17);

        // T3: zero length, unaligned low bits ignored
        pulse_start(1'b0, 32'h5000, 32'h6000, 32'd3);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_host_req", {31'd0, host_req}, 32'd0);
        chk("t3_dev_req", {31'd0, dev_req}, 32'd0);
        step();
        chk("t3_c2_busy", {31'd0, busy}, 32'd0);
        chk("t3_c2_done", {31'd0, done}, 32'd1);

        // T4: three stall cycles on every request, unaligned src/dst truncated
        host_stall = 3;
        dev_stall  = 3;
        exp_q.push_back('{1'b0, 32'h300, 32'hDEAD_BEEF});
        exp_q.push_back('{1'b0, 32'h304, 32'hCAFE_F00D});
        pulse_start(1'b0, 32'h2003, 32'h302, 32'd8);
        step();
        chk("t4_c2_host_req", {31'd0, host_req}, 32'd1);
        chk("t4_c2_host_addr", host_addr, 32'h2000);
        wait_done(2, c);
        chk("t4_cycles", 32'(c), 32'd21);
        host_stall = 0;
        dev_stall  = 0;

        // T5: second start while busy must be ignored
        exp_q.push_back('{1'b0, 32'h400, 32'h1111_1111});
        exp_q.push_back('{1'b0, 32'h404, 32'h2222_2222});
        pulse_start(1'b0, 32'h2100, 32'h400, 32'd8);
        step();
        step();
        dir = 1'b1; src = 32'h3000; dst = 32'h500; len = 32'd16; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(4, c);
        chk("t5_cycles", 32'(c), 32'd9);

        // T6: reset in WR_WAIT of the first word, then a fresh transfer
        exp_q.push_back('{1'b0, 32'h600, 32'h5500_0000});
        pulse_start(1'b0, 32'h2200, 32'h600, 32'd16);
        step();
        step();
        step();
        chk("t6_busy_before", {31'd0, busy}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_host_req", {31'd0, host_req}, 32'd0);
        chk("t6_rst_dev_req", {31'd0, dev_req}, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        exp_q.push_back('{1'b0, 32'h700, 32'h5500_0001});
        pulse_start(1'b0, 32'h2204, 32'h700, 32'd4);
        wait_done(1, c);
        chk("t6_cycles", 32'(c), 32'd5);

        step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
